// File: rtl/hovalaag_pkg.sv
// Shared types and width constants for the Hovalaag run controller.
package hovalaag_pkg;

    localparam int DATA_W  = 12;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE     = 2'd0,
        ST_OK       = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_UNDERRUN = 2'd3
    } status_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hovalaag_fifo.sv
// Synchronous FIFO with a combinational head. A push into a full FIFO is
// accepted only when a pop frees a slot on the same edge; a pop of an
// empty FIFO is ignored.
module hovalaag_fifo
    import hovalaag_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hovalaag_run_ctrl.sv
// Run controller for an external Hovalaag CPU: holds the program memory,
// feeds two input FIFOs, collects outputs and decides when a run stops.
module hovalaag_run_ctrl
    import hovalaag_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        cycle_limit,
    input  logic [7:0]         out_target,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               in1_push,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in2_push,
    input  logic [DATA_W-1:0]  in2_data,
    output logic               cpu_rst,
    output logic [INSTR_W-1:0] cpu_instr,
    input  logic [PC_W-1:0]    cpu_pc,
    output logic [DATA_W-1:0]  cpu_in1,
    input  logic               cpu_in1_adv,
    output logic [DATA_W-1:0]  cpu_in2,
    input  logic               cpu_in2_adv,
    input  logic [DATA_W-1:0]  cpu_out,
    input  logic               cpu_out_valid,
    input  logic               cpu_out_select,
    output logic               out_valid,
    output logic               out_sel,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic               overflow,
    output logic [15:0]        cycles,
    output logic [7:0]         out_count
);

    // state | meaning
    // IDLE  | CPU held in reset, waiting for start
    // RUN   | CPU executing; outputs collected, stop conditions watched
    // DONE  | CPU held in reset, status frozen until the next start

    state_t state;
    status_t status_q;
    logic run_d;

    logic [INSTR_W-1:0] prog_mem [0:(1<<PC_W)-1];

    logic [DATA_W-1:0] head1, head2;
    logic empty1, empty2, full1, full2;
    logic pop1, pop2, drop1, drop2;
    logic in_run, underrun, out_fire, hit_ok, hit_timeout;
    logic [7:0] count_next;

    // Program memory is writable only while the CPU is held in reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state != RUN)) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    assign cpu_instr = prog_mem[cpu_pc];

    hovalaag_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (in1_push),
        .pop       (pop1),
        .push_data (in1_data),
        .head      (head1),
        .empty     (empty1),
        .full      (full1)
    );

    hovalaag_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo2 (
        .clk       (clk),
        .rst       (rst),
        .push      (in2_push),
        .pop       (pop2),
        .push_data (in2_data),
        .head      (head2),
        .empty     (empty2),
        .full      (full2)
    );

    assign cpu_in1 = empty1 ? '0 : head1;
    assign cpu_in2 = empty2 ? '0 : head2;

    // Pops only happen in a live RUN cycle and never from an empty FIFO,
    // so an underrun leaves the pointers untouched.
    assign in_run = (state == RUN) && !abort;
    assign pop1   = in_run && cpu_in1_adv && !empty1;
    assign pop2   = in_run && cpu_in2_adv && !empty2;
    assign drop1  = in1_push && full1 && !pop1;
    assign drop2  = in2_push && full2 && !pop2;

    // run_d masks the stale valid the CPU presents on its first cycle out of reset.
    assign out_fire    = (state == RUN) && run_d && cpu_out_valid;
    assign count_next  = out_count + {7'd0, out_fire};
    assign underrun    = (cpu_in1_adv && empty1) || (cpu_in2_adv && empty2);
    assign hit_ok      = (out_target != 8'd0) && (count_next >= out_target);
    assign hit_timeout = (cycle_limit != 16'd0) && ((cycles + 16'd1) == cycle_limit);

    assign status = status_q;

    // Run sequencing FSM with registered status/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            run_d     <= 1'b0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            status_q  <= ST_NONE;
            overflow  <= 1'b0;
            cycles    <= 16'd0;
            out_count <= 8'd0;
            out_valid <= 1'b0;
            out_sel   <= 1'b0;
            out_data  <= '0;
        end else begin
            run_d     <= (state == RUN);
            out_valid <= 1'b0;
            overflow  <= overflow | drop1 | drop2;
            if (abort) begin
                state   <= IDLE;
                cpu_rst <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state     <= RUN;
                            cpu_rst   <= 1'b0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            cycles    <= 16'd0;
                            out_count <= 8'd0;
                            status_q  <= ST_NONE;
                        end
                    end
                    RUN: begin
                        cycles <= sat_inc16(cycles);
                        if (out_fire) begin
                            out_valid <= 1'b1;
                            out_sel   <= cpu_out_select;
                            out_data  <= cpu_out;
                            out_count <= count_next;
                        end
                        if (underrun || hit_ok || hit_timeout) begin
                            state   <= DONE;
                            cpu_rst <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            if (underrun) begin
                                status_q <= ST_UNDERRUN;
                            end else if (hit_ok) begin
                                status_q <= ST_OK;
                            end else begin
                                status_q <= ST_TIMEOUT;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hovalaag_run_ctrl.sv
// Directed bench for hovalaag_run_ctrl: a per-cycle vector table for the
// basic output-collection run, then hand sequences for the multi-cycle cases.
module tb_hovalaag_run_ctrl;

    logic        clk;
    logic        rst;
    logic        start, abort;
    logic [15:0] cycle_limit;
    logic [7:0]  out_target;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        in1_push, in2_push;
    logic [11:0] in1_data, in2_data;
    logic        cpu_rst;
    logic [31:0] cpu_instr;
    logic [7:0]  cpu_pc;
    logic [11:0] cpu_in1, cpu_in2;
    logic        cpu_in1_adv, cpu_in2_adv;
    logic [11:0] cpu_out;
    logic        cpu_out_valid, cpu_out_select;
    logic        out_valid, out_sel;
    logic [11:0] out_data;
    logic        busy, done;
    logic [1:0]  status;
    logic        overflow;
    logic [15:0] cycles;
    logic [7:0]  out_count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] PROG0   = 32'h0500_8000;
    localparam logic [31:0] PROG1   = 32'h1234_5678;
    localparam logic [31:0] PROG255 = 32'hCAFE_F00D;

    hovalaag_run_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cycle_limit    (cycle_limit),
        .out_target     (out_target),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .in1_push       (in1_push),
        .in1_data       (in1_data),
        .in2_push       (in2_push),
        .in2_data       (in2_data),
        .cpu_rst        (cpu_rst),
        .cpu_instr      (cpu_instr),
        .cpu_pc         (cpu_pc),
        .cpu_in1        (cpu_in1),
        .cpu_in1_adv    (cpu_in1_adv),
        .cpu_in2        (cpu_in2),
        .cpu_in2_adv    (cpu_in2_adv),
        .cpu_out        (cpu_out),
        .cpu_out_valid  (cpu_out_valid),
        .cpu_out_select (cpu_out_select),
        .out_valid      (out_valid),
        .out_sel        (out_sel),
        .out_data       (out_data),
        .busy           (busy),
        .done           (done),
        .status         (status),
        .overflow       (overflow),
        .cycles         (cycles),
        .out_count      (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic        ov;
        logic        osel;
        logic [11:0] odata;
        logic        e_busy;
        logic        e_cpu_rst;
        logic        e_done;
        logic [1:0]  e_status;
        logic        e_ovalid;
        logic        e_osel;
        logic [11:0] e_odata;
        logic [7:0]  e_count;
        logic [15:0] e_cycles;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic st, ab, ov, osel, input logic [11:0] od,
                                input logic eb, er, ed, input logic [1:0] es,
                                input logic ev, esel, input logic [11:0] edat,
                                input logic [7:0] ec, input logic [15:0] ecy);
        vec_t v;
        v.start = st; v.abort = ab; v.ov = ov; v.osel = osel; v.odata = od;
        v.e_busy = eb; v.e_cpu_rst = er; v.e_done = ed; v.e_status = es;
        v.e_ovalid = ev; v.e_osel = esel; v.e_odata = edat;
        v.e_count = ec; v.e_cycles = ecy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " busy"},     32'(busy),      32'd0);
        chk({tag, " cpu_rst"},  32'(cpu_rst),   32'd1);
        chk({tag, " done"},     32'(done),      32'd0);
        chk({tag, " status"},   32'(status),    32'd0);
        chk({tag, " overflow"}, 32'(overflow),  32'd0);
        chk({tag, " cycles"},   32'(cycles),    32'd0);
        chk({tag, " count"},    32'(out_count), 32'd0);
        chk({tag, " ovalid"},   {19'd0, out_valid, out_sel, out_data}, 32'd0);
        chk({tag, " in1"},      32'(cpu_in1),   32'd0);
        chk({tag, " in2"},      32'(cpu_in2),   32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 0; abort = 0; cycle_limit = 0; out_target = 0;
        prog_we = 0; prog_addr = 0; prog_data = 0;
        in1_push = 0; in1_data = 0; in2_push = 0; in2_data = 0;
        cpu_pc = 0; cpu_in1_adv = 0; cpu_in2_adv = 0;
        cpu_out = 0; cpu_out_valid = 0; cpu_out_select = 0;
        repeat (2) tick();
        check_reset_vals("reset");
        rst = 1'b0;

        prog_write(8'd0, PROG0);
        prog_write(8'd1, PROG1);
        prog_write(8'd255, PROG255);
        cpu_pc = 8'd1;   #1; chk("instr pc1",   cpu_instr, PROG1);
        cpu_pc = 8'd255; #1; chk("instr pc255", cpu_instr, PROG255);
        cpu_pc = 8'd0;   #1; chk("instr pc0",   cpu_instr, PROG0);

        // Output-collection run: CPU emits 5 on OUT1; first RUN cycle carries a stale 7.
        out_target = 8'd3; cycle_limit = 16'd0;
        //              st ab ov sl data   busy rst done st  ov sel edat   cnt cyc
        tbl[0]  = mk(1, 0, 1, 1, 12'h007, 1, 0, 0, 2'd0, 0, 0, 12'h000, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 12'h007, 1, 0, 0, 2'd0, 0, 0, 12'h000, 0, 1);
        tbl[2]  = mk(0, 0, 1, 0, 12'h005, 1, 0, 0, 2'd0, 1, 0, 12'h005, 1, 2);
        tbl[3]  = mk(0, 0, 0, 0, 12'h005, 1, 0, 0, 2'd0, 0, 0, 12'h000, 1, 3);
        tbl[4]  = mk(0, 0, 1, 0, 12'h005, 1, 0, 0, 2'd0, 1, 0, 12'h005, 2, 4);
        tbl[5]  = mk(0, 0, 1, 0, 12'h005, 0, 1, 1, 2'd1, 1, 0, 12'h005, 3, 5);
        tbl[6]  = mk(0, 0, 1, 0, 12'h005, 0, 1, 1, 2'd1, 0, 0, 12'h000, 3, 5);
        tbl[7]  = mk(1, 0, 0, 0, 12'h000, 1, 0, 0, 2'd0, 0, 0, 12'h000, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 12'h000, 1, 0, 0, 2'd0, 0, 0, 12'h000, 0, 1);
        tbl[9]  = mk(1, 1, 0, 0, 12'h000, 0, 1, 0, 2'd0, 0, 0, 12'h000, 0, 1);
        tbl[10] = mk(1, 1, 0, 0, 12'h000, 0, 1, 0, 2'd0, 0, 0, 12'h000, 0, 1);
        for (int k = 0; k < 11; k++) begin
            start = tbl[k].start; abort = tbl[k].abort;
            cpu_out_valid = tbl[k].ov; cpu_out_select = tbl[k].osel; cpu_out = tbl[k].odata;
            tick();
            chk($sformatf("row%0d ctrl", k),
                {2'd0, busy, cpu_rst, done, status, out_valid, out_count, cycles},
                {2'd0, tbl[k].e_busy, tbl[k].e_cpu_rst, tbl[k].e_done, tbl[k].e_status,
                 tbl[k].e_ovalid, tbl[k].e_count, tbl[k].e_cycles});
            if (tbl[k].e_ovalid)
                chk($sformatf("row%0d data", k), {19'd0, out_sel, out_data},
                    {19'd0, tbl[k].e_osel, tbl[k].e_odata});
        end
        start = 0; abort = 0; cpu_out_valid = 0;

        // Underrun: two values in FIFO1, CPU reads IN1 every cycle.
        out_target = 0; cycle_limit = 0;
        in1_push = 1; in1_data = 12'h111; tick();
        in1_data = 12'h222; tick();
        in1_push = 0;
        chk("in1 head idle", cpu_in1, 12'h111);
        chk("in2 empty", cpu_in2, 12'h000);
        start = 1; tick(); start = 0;
        cpu_in1_adv = 1;
        chk("ur in1 a", cpu_in1, 12'h111); tick();
        chk("ur in1 b", cpu_in1, 12'h222); tick();
        chk("ur running", {busy, status}, {1'b1, 2'd0});
        chk("ur in1 empty", cpu_in1, 12'h000); tick();
        cpu_in1_adv = 0;
        chk("ur stop", {cpu_rst, done, status}, {1'b1, 1'b1, 2'd3});
        chk("ur fifo empty", cpu_in1, 12'h000);
        in1_push = 1; in1_data = 12'h333; tick(); in1_push = 0;
        chk("ur ptr intact", cpu_in1, 12'h333);

        // Priority: UNDERRUN over OK on the same cycle.
        out_target = 8'd1; cycle_limit = 0;
        start = 1; tick(); start = 0;
        tick();
        cpu_out_valid = 1; cpu_in2_adv = 1; tick();
        cpu_out_valid = 0; cpu_in2_adv = 0;
        chk("prio ur>ok", {done, status}, {1'b1, 2'd3});

        // Priority: OK over TIMEOUT on the same cycle.
        out_target = 8'd1; cycle_limit = 16'd2;
        start = 1; tick(); start = 0;
        tick();
        cpu_out_valid = 1; tick(); cpu_out_valid = 0;
        chk("prio ok>to", {done, status}, {1'b1, 2'd1});

        // Timeout after exactly 10 RUN cycles.
        out_target = 0; cycle_limit = 16'd10;
        start = 1; tick(); start = 0;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("to run cycles", 32'(n), 32'd10);
        chk("to cycles", 32'(cycles), 32'd10);
        chk("to status", 32'(status), 32'd2);

        // Overflow on FIFO2, then drain in order with a push on the full-and-popping cycle.
        cycle_limit = 0; out_target = 0;
        for (int i = 0; i < 17; i++) begin
            in2_push = 1; in2_data = 12'h100 + 12'(i); tick();
            if (i == 15) chk("ovf not yet", 32'(overflow), 32'd0);
        end
        in2_push = 0;
        chk("ovf set", 32'(overflow), 32'd1);
        start = 1; tick(); start = 0;
        for (int i = 0; i < 17; i++) begin
            cpu_in2_adv = 1;
            if (i == 0) begin
                in2_push = 1; in2_data = 12'h1FF;
                prog_we = 1; prog_addr = 8'd0; prog_data = 32'hDEAD_BEEF;
            end
            chk($sformatf("drain %0d", i), cpu_in2, (i < 16) ? 12'h100 + 12'(i) : 12'h1FF);
            tick();
            in2_push = 0; prog_we = 0;
        end
        cpu_in2_adv = 0;
        chk("drain empty", {busy, cpu_in2}, {1'b1, 12'h000});
        abort = 1; tick(); abort = 0;
        chk("ovf sticky", {busy, overflow}, {1'b0, 1'b1});
        cpu_pc = 8'd0; #1;
        chk("run write ignored", cpu_instr, PROG0);

        // Synchronous reset mid-RUN with a live output on the reset edge.
        cpu_out_valid = 1; cpu_out = 12'hABC; cpu_out_select = 1;
        start = 1; tick(); start = 0;
        repeat (3) tick();
        chk("pre-rst count", 32'(out_count), 32'd2);
        rst = 1; tick(); rst = 0;
        cpu_out_valid = 0;
        check_reset_vals("midrst");
        cpu_pc = 8'd1;   #1; chk("mem kept pc1", cpu_instr, PROG1);
        cpu_pc = 8'd255; #1; chk("mem kept pc255", cpu_instr, PROG255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hovalaag_run_ctrl.md
HOVALAAG_RUN_CTRL -- requirements
Module: hovalaag_run_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16 (power of two), entries per input FIFO.
REQ-002 Ports, clock and reset first: clk in 1, system clock; rst in 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 Host ports: start in 1 (begin run); abort in 1 (return to IDLE); cycle_limit in 16 (max RUN cycles, 0 = unlimited); out_target in 8 (outputs to collect, 0 = unlimited).
REQ-004 Program write port: prog_we in 1; prog_addr in 8; prog_data in 32.
REQ-005 Input push ports: in1_push in 1; in1_data in 12; in2_push in 1; in2_data in 12.
REQ-006 CPU-facing ports: cpu_rst out 1; cpu_instr out 32; cpu_pc in 8; cpu_in1 out 12; cpu_in1_adv in 1; cpu_in2 out 12; cpu_in2_adv in 1; cpu_out in 12; cpu_out_valid in 1; cpu_out_select in 1.
REQ-007 Result ports: out_valid out 1; out_sel out 1; out_data out 12; busy out 1; done out 1; status out 2; overflow out 1; cycles out 16; out_count out 8.

Function
REQ-010 Internal 256x32 program memory; cpu_instr SHALL equal mem[cpu_pc] combinationally, with no cycle of latency.
REQ-011 prog_we writes prog_data to mem[prog_addr] only in IDLE or DONE; writes in RUN are ignored.
REQ-012 Two FIFOs of FIFO_DEPTH x 12 bits; cpu_inN SHALL equal the FIFO head, or 0 when that FIFO is empty.
REQ-013 cpu_inN_adv pops one entry per cycle.
REQ-014 A push into a full FIFO is dropped and sets overflow, which is sticky until reset.
REQ-015 A simultaneous push and pop on a full FIFO is accepted.
REQ-016 Pushes are allowed in every state.
REQ-017 States are IDLE, RUN, DONE; cpu_rst = 1 in IDLE and DONE, 0 in RUN; busy = (state == RUN).
REQ-018 IDLE/DONE + start -> RUN; the transition clears cycles, out_count, status and done.
REQ-019 In RUN, cycles increments every cycle and saturates at 0xFFFF.
REQ-020 cpu_out_valid SHALL be ignored in the first RUN cycle (stale value captured while the CPU was held in reset); it is qualified by a one-cycle-delayed RUN flag.
REQ-021 A qualified cpu_out_valid registers out_valid=1, out_sel=cpu_out_select and out_data=cpu_out on the next edge, and increments out_count.
REQ-022 out_valid is a one-cycle pulse per output.
REQ-023 RUN -> DONE on the first of these conditions:
  - UNDERRUN (status 3): cpu_inN_adv while FIFO N is empty;
  - OK (status 1): out_count reaches out_target, with out_target != 0, counting the output captured that cycle;
  - TIMEOUT (status 2): cycles+1 == cycle_limit, with cycle_limit != 0.
REQ-024 Priority when stop conditions coincide: UNDERRUN > OK > TIMEOUT.
REQ-025 done = 1 throughout DONE; status holds its value until the next start.
REQ-026 abort in any state -> IDLE with cpu_rst = 1, and overrides start in the same cycle.
REQ-027 FIFO contents, program memory, overflow and counters are retained across abort.
REQ-028 start while in RUN is ignored.
REQ-029 An underrun pop is not performed; the FIFO pointers are unchanged.

Reset
REQ-030 rst SHALL force state=IDLE, cpu_rst=1, both FIFOs empty, overflow=0, cycles=0, out_count=0, status=0, done=0, out_valid=0, out_sel=0, out_data=0.
REQ-031 Program memory is not cleared by rst.
REQ-032 rst asserted mid-RUN SHALL take effect on that edge: no output is captured and no status is written.

Structure
REQ-040 Package hovalaag_pkg SHALL hold the state enum (IDLE, RUN, DONE), the status codes (NONE=0, OK=1, TIMEOUT=2, UNDERRUN=3) and the width constants (data 12, instruction 32, PC 8).
REQ-041 Sub-module hovalaag_fifo (synchronous FIFO exposing head, empty, full, push, pop) SHALL be instantiated twice.
REQ-042 Program memory and the FSM live in hovalaag_run_ctrl.

Verification
REQ-050 Load mem[0]={W<=K=5, OUT1 set, jump 0}; out_target=3; start -> three out_valid pulses, out_sel=0, out_data=5 after the first; then done=1, status=1.
REQ-051 Program that reads IN1 forever; push 2 values; start -> the third cpu_in1_adv causes status=3, cpu_rst=1 next cycle, and FIFO1 empty.
REQ-052 Tight loop emitting nothing; cycle_limit=10 -> done after exactly 10 RUN cycles, cycles=10, status=2.
REQ-053 mem[0] has OUT bit set; verify no out_valid in the first RUN cycle and out_count stays 0 while cpu_rst=1.
REQ-054 Push FIFO_DEPTH+1 values into FIFO2 in IDLE -> overflow=1; 16 entries retained in order.
REQ-055 Assert abort and start together mid-RUN -> IDLE; assert rst mid-RUN -> all REQ-030 values next cycle, and program memory is intact.
